// File: rtl/fetch_queue_ctrl.sv
// Fetch-to-decode queue for the dual-issue core: throttles fetch, buffers fetched
// instructions in a circular queue and presents the two oldest entries to decode.
module fetch_queue_ctrl #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                InstrF,
    input  logic [31:0]                PCF,
    input  logic [31:0]                PCPlus4F,
    input  logic                       RedirectE,
    input  logic [1:0]                 PopD,
    output logic                       FetchEnF,
    output logic                       Valid0D,
    output logic [31:0]                Instr0D,
    output logic [31:0]                PC0D,
    output logic [31:0]                PCPlus40D,
    output logic                       Valid1D,
    output logic [31:0]                Instr1D,
    output logic [31:0]                PC1D,
    output logic [31:0]                PCPlus41D,
    output logic [$clog2(DEPTH):0]     CountQ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 96;

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_plus1_next;
    logic [CW-1:0] count_reg, count_next;

    logic          full;
    logic          push;
    logic [1:0]    pop_req;
    logic [1:0]    pop;
    logic [EW-1:0] wdata;

    logic [EW-1:0] entry_reg  [DEPTH];
    logic [EW-1:0] entry_view [DEPTH];
    logic [EW-1:0] slot0_reg, slot1_reg;

    assign wdata = {InstrF, PCF, PCPlus4F};
    assign full  = (count_reg == CW'(DEPTH));

    // A full queue stalls fetch even if decode drains it this cycle.
    assign FetchEnF = !rst && (RedirectE || !full);
    assign push     = !rst && !RedirectE && !full;

    always_comb begin
        pop_req = PopD[1] ? 2'd2 : {1'b0, PopD[0]};
        pop     = pop_req;
        if (CW'(pop_req) > count_reg) begin
            pop = count_reg[1:0];
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (RedirectE) begin
            rd_ptr_next = wr_ptr_reg;
            wr_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PW'(pop);
            wr_ptr_next = wr_ptr_reg + PW'(push);
            count_next  = count_reg + CW'(push) - CW'(pop);
        end
    end

    assign rd_ptr_plus1_next = rd_ptr_next + PW'(1);

    // entry_view is the array as it will look after this edge, so the slot registers
    // can capture an entry in the same cycle it is written.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_view[gi] = (push && (wr_ptr_reg == PW'(gi))) ? wdata : entry_reg[gi];

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        slot0_reg <= entry_view[rd_ptr_next];
        slot1_reg <= entry_view[rd_ptr_plus1_next];
    end

    assign CountQ  = count_reg;
    assign Valid0D = (count_reg != '0);
    assign Valid1D = (count_reg >= CW'(2));

    assign Instr0D   = Valid0D ? slot0_reg[95:64] : NOP;
    assign PC0D      = Valid0D ? slot0_reg[63:32] : 32'h0;
    assign PCPlus40D = Valid0D ? slot0_reg[31:0]  : 32'h0;
    assign Instr1D   = Valid1D ? slot1_reg[95:64] : NOP;
    assign PC1D      = Valid1D ? slot1_reg[63:32] : 32'h0;
    assign PCPlus41D = Valid1D ? slot1_reg[31:0]  : 32'h0;

endmodule
